store_rmw_ctrl: RTL and testbench
=================================

# store_rmw_ctrl

Store sequencer between the MEM stage and the word-wide data RAM. Word stores are written in one cycle. Byte and halfword stores use read-modify-write: read the containing word, merge the new bytes into it, then write it back. While a store is in flight the block stalls the pipeline.

## Interface
Parameters:
- `ADDR_W`, default 14: word-address width of the data RAM.
- `RD_LAT`, default 1: data-RAM read latency in cycles, legal range 1..4.

Ports:
- `cpu_clk`  in  1  system clock; all state changes on the rising edge.
- `cpu_rst`  in  1  asynchronous, active-high reset.
- `st_valid`  in  1  store request present.
- `st_ready`  out  1  block can accept a request; high only in IDLE.
- `st_op`  in  2  store width, encoded with the shared `WB_BYTE` / `WB_HEX` / `WB_WORD` codes.
- `st_addr`  in  32  byte address.
- `st_data`  in  32  store data, right-aligned.
- `st_done`  out  1  one-cycle pulse in the cycle the RAM write occurs.
- `st_misalign`  out  1  one-cycle pulse when a request is rejected.
- `stall`  out  1  pipeline hold.
- `ram_addr`  out  `ADDR_W`  RAM word address, equal to `st_addr[ADDR_W+1:2]` of the accepted request.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  32  RAM write word.
- `ram_rdata`  in  32  RAM read word; valid `RD_LAT` cycles after the address is presented.

## Operation
- **States:** IDLE, READ, WRITE.
- **Accept:** a handshake is `st_valid & st_ready`. On a handshake the block registers op, address, data and the byte offset `sel = st_addr[1:0]`.
- **Transitions from IDLE** (on handshake):
  - `WB_WORD` → WRITE.
  - `WB_BYTE`, or `WB_HEX` with `sel` = 00/01/10 → READ.
  - `WB_HEX` with `sel` = 11 → stays in IDLE, pulses `st_misalign`, no RAM access.
  - Undefined `st_op` code → treated as misaligned.
- **READ:**
  - `ram_addr` is held and `ram_we` = 0.
  - A 2-bit counter runs `RD_LAT` cycles.
  - In the last READ cycle `ram_rdata` is captured into `old_word`, then → WRITE.
- **WRITE:**
  - `ram_we` = 1 and `st_done` = 1 for exactly one cycle, then → IDLE.
  - `ram_wdata` for `WB_WORD` is `st_data`.
  - `ram_wdata` for sub-word stores is `old_word` merged with the new data:
    - Byte: `st_data[7:0]` replaces byte lane `sel`.
    - Halfword: `st_data[15:0]` replaces bits `[8*sel+15 : 8*sel]`.
    - All other bits keep their `old_word` values.
- **`stall`:** `st_valid & (state != IDLE)`, plus `st_valid` in IDLE for any non-word store that will enter READ. Stalling in the accept cycle keeps the pipeline from advancing past an unfinished RMW.
- **Back-to-back requests:** a request arriving while the block is busy is held by the requester (`st_ready` = 0). It is accepted on the IDLE cycle after WRITE, so there are no overlapping RAM cycles.
- **Reset values:** state = IDLE, counter = 0, `old_word` = 0.
- **Reset mid-operation:** any in-flight store is abandoned with no RAM write. `ram_we` drops asynchronously with `cpu_rst`.

## Timing
- Output values during reset: `st_ready`=0, `st_done`=0, `st_misalign`=0, `stall`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0. `st_ready` rises in the first cycle after reset deasserts.
- Handshake in cycle T for a word store: `ram_we`/`st_done` in T+1.
- Handshake in cycle T for a sub-word store:
  - READ in T+1 .. T+`RD_LAT`.
  - WRITE in T+1+`RD_LAT`.
  - IDLE again in T+2+`RD_LAT`.
- Misaligned request: `st_misalign` is registered and pulses in T+1. `st_ready` stays 1.
- Throughput:
  - Word stores: 1 per 2 cycles.
  - Sub-word stores: 1 per `RD_LAT`+2 cycles.
- `ram_addr` is stable from T+1 through the WRITE cycle inclusive.
- All outputs are registered or decoded from state only, except `stall`, which also depends on `st_valid` and `st_op`.

## Structure
- The shared defines header holds `WB_BYTE`, `WB_HEX`, `WB_WORD` and the state encodings `RMW_IDLE`, `RMW_READ`, `RMW_WRITE`.
- The sub-module `store_merge` is purely combinational. Its inputs are op, `sel`, the old word and the store data; its output is the merged word. The controller instantiates it once, fed from its registers.
- The controller holds the FSM, the latency counter, the request registers and `old_word`.

## Test plan
- **Word store:** `WB_WORD`, addr 0x0000_0010, data 0xDEADBEEF. Expect: `ram_we`=1, `ram_addr`=4, `ram_wdata`=0xDEADBEEF at T+1; `st_done` pulses once.
- **Byte store, `RD_LAT`=1:** RAM word 0x11223344, `WB_BYTE`, addr offset 2, data 0xAB. Expect: READ at T+1; write of 0x11AB3344 at T+2.
- **Halfword store, `RD_LAT`=3:** old word 0x11223344, `WB_HEX`, offset 1, data 0xCAFE. Expect: write of 0x11CAFE44 at T+4; `stall` high T..T+3.
- **Misaligned halfword:** `WB_HEX`, offset 3. Expect: `st_misalign` pulse at T+1, no `ram_we`, block stays in IDLE.
- **Back-to-back:** byte store followed immediately by a word store with `st_valid` held. Expect: the second handshake in the IDLE cycle after the first WRITE and no overlapping `ram_we`.
- **Reset mid-operation:** assert `cpu_rst` during READ. Expect: no `ram_we` at any time, all outputs at their reset values immediately, `st_ready`=1 in the cycle after release.

Source files
------------

// File: rtl/store_rmw_ctrl_pkg.sv
// Shared store-width codes, RMW state encoding and request classification
// for the store sequencer.
package store_rmw_ctrl_pkg;

   localparam logic [1:0] WB_BYTE = 2'b00;
   localparam logic [1:0] WB_HEX  = 2'b01;
   localparam logic [1:0] WB_WORD = 2'b10;

   typedef enum logic [1:0] {
      RMW_IDLE  = 2'b00,
      RMW_READ  = 2'b01,
      RMW_WRITE = 2'b10
   } rmw_state_e;

   // Sub-word stores that fit inside one word go through read-modify-write.
   function automatic logic needs_rmw(input logic [1:0] op, input logic [1:0] sel);
      return (op == WB_BYTE) || ((op == WB_HEX) && (sel != 2'b11));
   endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Store request and data-RAM signals. The master side is the pipeline/RAM
// environment; the slave side is the sequencer.
interface store_rmw_ctrl_if #(parameter int ADDR_W = 14);
   logic              st_valid;
   logic              st_ready;
   logic [1:0]        st_op;
   logic [31:0]       st_addr;
   logic [31:0]       st_data;
   logic              st_done;
   logic              st_misalign;
   logic              stall;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport master (
      output st_valid, st_op, st_addr, st_data, ram_rdata,
      input  st_ready, st_done, st_misalign, stall, ram_addr, ram_we, ram_wdata
   );

   modport slave (
      input  st_valid, st_op, st_addr, st_data, ram_rdata,
      output st_ready, st_done, st_misalign, stall, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/store_rmw_ctrl_merge.sv
// Combinational merge of store data into the old RAM word; word stores
// pass the store data through unchanged.
module store_merge
   import store_rmw_ctrl_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic [1:0]  sel_i,
   input  logic [31:0] old_i,
   input  logic [31:0] data_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      case (op_i)
         WB_WORD: merged_o = data_i;
         WB_BYTE: begin
            case (sel_i)
               2'd0: merged_o[7:0]   = data_i[7:0];
               2'd1: merged_o[15:8]  = data_i[7:0];
               2'd2: merged_o[23:16] = data_i[7:0];
               default: merged_o[31:24] = data_i[7:0];
            endcase
         end
         WB_HEX: begin
            case (sel_i)
               2'd0: merged_o[15:0]  = data_i[15:0];
               2'd1: merged_o[23:8]  = data_i[15:0];
               2'd2: merged_o[31:16] = data_i[15:0];
               default: merged_o = old_i;
            endcase
         end
         default: merged_o = old_i;
      endcase
   end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer: one-cycle word writes, read-modify-write for byte and
// halfword stores, pipeline stall while a store is in flight.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   RMW_IDLE  | ready for a request; misaligned requests rejected here
//   RMW_READ  | RAM address held, waiting RD_LAT cycles for read data
//   RMW_WRITE | single RAM write cycle, st_done pulses
module store_rmw_ctrl
   import store_rmw_ctrl_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 1
)(
   input  logic cpu_clk,
   input  logic cpu_rst,
   store_rmw_ctrl_if.slave bus
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   rmw_state_e        state_q;
   logic [1:0]        cnt_q;
   logic [1:0]        op_q;
   logic [1:0]        sel_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [31:0]       old_word_q;
   logic              ready_q;
   logic              done_q;
   logic              misalign_q;
   logic              we_q;
   logic              accept;
   logic              unused_addr_hi;

   assign accept         = bus.st_valid & ready_q;
   assign unused_addr_hi = ^bus.st_addr[31:ADDR_W+2];

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q    <= RMW_IDLE;
         cnt_q      <= 2'd0;
         op_q       <= 2'd0;
         sel_q      <= 2'd0;
         addr_q     <= '0;
         data_q     <= 32'd0;
         old_word_q <= 32'd0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         we_q       <= 1'b0;
         case (state_q)
            RMW_IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  op_q   <= bus.st_op;
                  sel_q  <= bus.st_addr[1:0];
                  addr_q <= bus.st_addr[ADDR_W+1:2];
                  data_q <= bus.st_data;
                  if (bus.st_op == WB_WORD) begin
                     state_q <= RMW_WRITE;
                     ready_q <= 1'b0;
                     we_q    <= 1'b1;
                     done_q  <= 1'b1;
                  end else if (needs_rmw(bus.st_op, bus.st_addr[1:0])) begin
                     state_q <= RMW_READ;
                     ready_q <= 1'b0;
                     cnt_q   <= LAT_LAST;
                  end else begin
                     misalign_q <= 1'b1;
                  end
               end
            end
            RMW_READ: begin
               if (cnt_q == 2'd0) begin
                  old_word_q <= bus.ram_rdata;
                  state_q    <= RMW_WRITE;
                  we_q       <= 1'b1;
                  done_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            RMW_WRITE: begin
               state_q <= RMW_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= RMW_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   store_merge u_merge (
      .op_i     (op_q),
      .sel_i    (sel_q),
      .old_i    (old_word_q),
      .data_i   (data_q),
      .merged_o (bus.ram_wdata)
   );

   // Stall already in the accept cycle of an RMW so the pipeline cannot run past it.
   assign bus.stall = bus.st_valid &
                      ((state_q != RMW_IDLE) |
                       (ready_q & needs_rmw(bus.st_op, bus.st_addr[1:0])));

   assign bus.st_ready    = ready_q;
   assign bus.st_done     = done_q;
   assign bus.st_misalign = misalign_q;
   assign bus.ram_addr    = addr_q;
   assign bus.ram_we      = we_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (read latency 1 and 3) driven
// with directed and random stores against a word-array RAM model.
module tb_store_rmw_ctrl;
   import store_rmw_ctrl_pkg::*;

   localparam int AW = 14;

   logic cpu_clk = 1'b0;
   logic cpu_rst;
   always #5 cpu_clk = ~cpu_clk;

   store_rmw_ctrl_if #(.ADDR_W(AW)) bus0 ();
   store_rmw_ctrl_if #(.ADDR_W(AW)) bus1 ();

   store_rmw_ctrl #(.ADDR_W(AW), .RD_LAT(1)) dut0 (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus0));
   store_rmw_ctrl #(.ADDR_W(AW), .RD_LAT(3)) dut1 (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus1));

   logic [1:0]    drv_valid;
   logic [1:0]    drv_op    [2];
   logic [31:0]   drv_addr  [2];
   logic [31:0]   drv_data  [2];
   logic [31:0]   drv_rdata [2];

   logic [1:0]    o_ready, o_done, o_mis, o_stall, o_we;
   logic [AW-1:0] o_addr  [2];
   logic [31:0]   o_wdata [2];

   assign bus0.st_valid  = drv_valid[0];
   assign bus0.st_op     = drv_op[0];
   assign bus0.st_addr   = drv_addr[0];
   assign bus0.st_data   = drv_data[0];
   assign bus0.ram_rdata = drv_rdata[0];
   assign bus1.st_valid  = drv_valid[1];
   assign bus1.st_op     = drv_op[1];
   assign bus1.st_addr   = drv_addr[1];
   assign bus1.st_data   = drv_data[1];
   assign bus1.ram_rdata = drv_rdata[1];

   assign o_ready  = {bus1.st_ready,    bus0.st_ready};
   assign o_done   = {bus1.st_done,     bus0.st_done};
   assign o_mis    = {bus1.st_misalign, bus0.st_misalign};
   assign o_stall  = {bus1.stall,       bus0.stall};
   assign o_we     = {bus1.ram_we,      bus0.ram_we};
   assign o_addr[0]  = bus0.ram_addr;
   assign o_addr[1]  = bus1.ram_addr;
   assign o_wdata[0] = bus0.ram_wdata;
   assign o_wdata[1] = bus1.ram_wdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [2][16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge cpu_clk);
      #2;
   endtask

   task automatic sample();
      @(negedge cpu_clk);
   endtask

   function automatic logic [31:0] ref_merge(input int nbytes, input int sel,
                                             input logic [31:0] old, input logic [31:0] data);
      logic [31:0] mask;
      mask = (nbytes == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      mask = mask << (8 * sel);
      return (old & ~mask) | ((data << (8 * sel)) & mask);
   endfunction

   task automatic check_reset_vals(input int i, input string tag);
      chk({tag, "_ready"}, 32'(o_ready[i]), 32'd0);
      chk({tag, "_done"},  32'(o_done[i]),  32'd0);
      chk({tag, "_mis"},   32'(o_mis[i]),   32'd0);
      chk({tag, "_stall"}, 32'(o_stall[i]), 32'd0);
      chk({tag, "_we"},    32'(o_we[i]),    32'd0);
      chk({tag, "_addr"},  32'(o_addr[i]),  32'd0);
      chk({tag, "_wdata"}, o_wdata[i],      32'd0);
   endtask

   task automatic idle_cycle(input int i);
      next_cycle();
      drv_valid[i] = 1'b0;
      sample();
      chk("idle_we",    32'(o_we[i]),    32'd0);
      chk("idle_ready", 32'(o_ready[i]), 32'd1);
      chk("idle_stall", 32'(o_stall[i]), 32'd0);
   endtask

   // One store from its accept cycle to its last cycle; b2b presents the
   // next request already during the WRITE cycle.
   task automatic do_store(input int i, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] d, input bit b2b, input logic [1:0] no,
                           input logic [31:0] na, input logic [31:0] nd);
      int lat_c, sel, idx, nbytes;
      bit word, reject;
      logic [AW-1:0] exp_addr;
      logic [31:0] exp_w;
      lat_c    = (i == 0) ? 1 : 3;
      sel      = int'(a[1:0]);
      idx      = int'(a[5:2]);
      nbytes   = (o == 2'd0) ? 1 : (o == 2'd1) ? 2 : (o == 2'd2) ? 4 : 0;
      word     = (nbytes == 4);
      reject   = (nbytes == 0) || (!word && (sel + nbytes > 4));
      exp_addr = a[AW+1:2];

      next_cycle();
      drv_valid[i] = 1'b1;
      drv_op[i]    = o;
      drv_addr[i]  = a;
      drv_data[i]  = d;
      drv_rdata[i] = $urandom;
      sample();
      chk("accept_ready", 32'(o_ready[i]), 32'd1);
      chk("accept_stall", 32'(o_stall[i]), 32'(!word && !reject));
      chk("accept_we",    32'(o_we[i]),    32'd0);

      if (reject) begin
         next_cycle();
         drv_valid[i] = 1'b0;
         sample();
         chk("mis_pulse", 32'(o_mis[i]),   32'd1);
         chk("mis_we",    32'(o_we[i]),    32'd0);
         chk("mis_ready", 32'(o_ready[i]), 32'd1);
         chk("mis_done",  32'(o_done[i]),  32'd0);
      end else begin
         if (!word) begin
            for (int k = 1; k <= lat_c; k++) begin
               next_cycle();
               drv_rdata[i] = (k == lat_c) ? mem[i][idx] : $urandom;
               sample();
               chk("read_ready", 32'(o_ready[i]), 32'd0);
               chk("read_stall", 32'(o_stall[i]), 32'd1);
               chk("read_we",    32'(o_we[i]),    32'd0);
               chk("read_addr",  32'(o_addr[i]),  32'(exp_addr));
            end
         end
         exp_w = word ? d : ref_merge(nbytes, sel, mem[i][idx], d);
         next_cycle();
         drv_valid[i] = b2b;
         drv_op[i]    = no;
         drv_addr[i]  = na;
         drv_data[i]  = nd;
         drv_rdata[i] = $urandom;
         sample();
         chk("write_we",    32'(o_we[i]),    32'd1);
         chk("write_done",  32'(o_done[i]),  32'd1);
         chk("write_addr",  32'(o_addr[i]),  32'(exp_addr));
         chk("write_data",  o_wdata[i],      exp_w);
         chk("write_stall", 32'(o_stall[i]), 32'(b2b));
         chk("write_ready", 32'(o_ready[i]), 32'd0);
         chk("write_mis",   32'(o_mis[i]),   32'd0);
         mem[i][idx] = exp_w;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  c_op, n_op;
      logic [31:0] c_a, n_a, c_d, n_d;
      bit          b2b, c_rej;
      logic [3:0]  ridx;
      logic [1:0]  rsel;

      cpu_rst   = 1'b1;
      drv_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
         drv_op[i]    = WB_BYTE;
         drv_addr[i]  = 32'h0000_0004;
         drv_data[i]  = 32'h0;
         drv_rdata[i] = 32'h0;
         for (int w = 0; w < 16; w++) mem[i][w] = $urandom;
      end
      repeat (2) @(posedge cpu_clk);
      sample();
      check_reset_vals(0, "rst0");
      check_reset_vals(1, "rst1");
      drv_valid = 2'b00;
      next_cycle();
      cpu_rst = 1'b0;
      sample();

      // Directed plan items
      do_store(0, WB_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'd0, 32'd0);
      mem[0][1] = 32'h1122_3344;
      do_store(0, WB_BYTE, 32'h0000_0006, 32'h0000_00AB, 1'b0, 2'd0, 32'd0, 32'd0);
      mem[1][2] = 32'h1122_3344;
      do_store(1, WB_HEX,  32'h0000_0009, 32'h0000_CAFE, 1'b0, 2'd0, 32'd0, 32'd0);
      do_store(0, WB_HEX,  32'h0000_000F, 32'h0000_1234, 1'b0, 2'd0, 32'd0, 32'd0);
      do_store(1, 2'b11,   32'h0000_0014, 32'h5555_AAAA, 1'b0, 2'd0, 32'd0, 32'd0);
      idle_cycle(1);
      do_store(0, WB_BYTE, 32'h0000_0021, 32'h0000_005A, 1'b1, WB_WORD, 32'h0000_0024, 32'h0123_4567);
      do_store(0, WB_WORD, 32'h0000_0024, 32'h0123_4567, 1'b0, 2'd0, 32'd0, 32'd0);
      do_store(1, WB_HEX,  32'h0000_0032, 32'h0000_BEEF, 1'b1, WB_BYTE, 32'h0000_0033, 32'h0000_0077);
      do_store(1, WB_BYTE, 32'h0000_0033, 32'h0000_0077, 1'b0, 2'd0, 32'd0, 32'd0);

      // Random stores, chained back-to-back at random
      for (int i = 0; i < 2; i++) begin
         ridx = 4'($urandom_range(0, 15));
         rsel = 2'($urandom_range(0, 3));
         c_op = 2'($urandom_range(0, 3));
         c_a  = {26'd0, ridx, rsel};
         c_d  = $urandom;
         for (int n = 0; n < 30; n++) begin
            ridx  = 4'($urandom_range(0, 15));
            rsel  = 2'($urandom_range(0, 3));
            n_op  = 2'($urandom_range(0, 3));
            n_a   = {26'd0, ridx, rsel};
            n_d   = $urandom;
            c_rej = (c_op == 2'b11) || (c_op == WB_HEX && c_a[1:0] == 2'b11);
            b2b   = ($urandom_range(0, 1) == 1) && !c_rej;
            do_store(i, c_op, c_a, c_d, b2b, n_op, n_a, n_d);
            if (!b2b && $urandom_range(0, 2) == 0) idle_cycle(i);
            c_op = n_op;
            c_a  = n_a;
            c_d  = n_d;
         end
      end

      // Reset while instance 1 is in READ
      next_cycle();
      drv_valid[1] = 1'b1;
      drv_op[1]    = WB_BYTE;
      drv_addr[1]  = 32'h0000_0035;
      drv_data[1]  = 32'h0000_00C3;
      sample();
      next_cycle();
      sample();
      chk("pre_rst_stall", 32'(o_stall[1]), 32'd1);
      #1;
      cpu_rst = 1'b1;
      #1;
      check_reset_vals(1, "midrst");
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("midrst_we", 32'(o_we[1]), 32'd0);
      end
      drv_valid[1] = 1'b0;
      next_cycle();
      cpu_rst = 1'b0;
      next_cycle();
      sample();
      chk("postrst_ready", 32'(o_ready[1]), 32'd1);
      chk("postrst_we",    32'(o_we[1]),    32'd0);
      do_store(1, WB_BYTE, 32'h0000_0035, 32'h0000_00C3, 1'b0, 2'd0, 32'd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
